// File: rtl/pix_out_pkg.sv
// pix_out_pkg: shared types and default sizes for the pixel read-out path
package pix_out_pkg;
   localparam int DATA_W = 8;
   localparam int FRAME_PIXELS = 304200;
   typedef enum logic [1:0] {IDLE, RUN, END} rd_state_t;
   typedef logic [DATA_W-1:0] pixel_t;
endpackage

// File: rtl/pix_fifo.sv
// pix_fifo: show-ahead FIFO; a full FIFO still accepts a write when a pop frees a slot
module pix_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic              full,
   input  logic              rd_en,
   output logic              valid,
   output logic [DATA_W-1:0] data
);
   localparam int AW = $clog2(DEPTH);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] occ;
   logic push, pop;
   assign full = occ == (AW+1)'(DEPTH);
   assign valid = occ != '0;
   assign data = valid ? mem[rd_ptr] : '0;
   assign pop = rd_en & valid;
   assign push = wr_en & (~full | pop);
   // storage write; contents need no reset since occupancy gates visibility
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= wr_data;
   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         occ <= occ + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
endmodule

// File: rtl/pixel_out_reader.sv
// pixel_out_reader: buffers stored pixels and streams them out with frame markers
module pixel_out_reader #(
   parameter int DATA_W = pix_out_pkg::DATA_W,
   parameter int DEPTH = 16,
   parameter int FRAME_PIXELS = pix_out_pkg::FRAME_PIXELS,
   parameter int CNT_W = 19
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              st_en,
   input  logic [DATA_W-1:0] st_data,
   output logic              st_full,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   input  logic              m_ready,
   output logic              frame_done,
   output logic [CNT_W-1:0]  pix_count,
   output logic              overflow
);
   import pix_out_pkg::*;
   rd_state_t state, nxt;
   logic hs, at_last;
   pix_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .wr_en(st_en),
      .wr_data(st_data),
      .full(st_full),
      .rd_en(m_ready),
      .valid(m_valid),
      .data(m_data)
   );
   assign hs = m_valid & m_ready;
   assign at_last = pix_count == CNT_W'(FRAME_PIXELS - 1);
   assign m_last = m_valid & at_last;
   assign frame_done = state == END;
   // the last handshake of a frame always enters END; otherwise follow output availability
   always_comb
      nxt = (hs && at_last) ? END : (state == RUN || m_valid) ? RUN : IDLE;
   // every accepted pixel advances the index, including the first one seen from IDLE or END
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         pix_count <= '0;
         overflow <= 1'b0;
      end else begin
         state <= nxt;
         if (hs) pix_count <= at_last ? '0 : pix_count + CNT_W'(1);
         if (st_en && st_full && !hs) overflow <= 1'b1;
      end
endmodule

// File: tb/tb_pixel_out_reader.sv
// tb_pixel_out_reader: scoreboard bench for the pixel read-out path
module tb_pixel_out_reader;
   localparam int DEPTH = 4;
   localparam int FP = 6;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic st_en = 1'b0;
   logic m_ready = 1'b0;
   logic [7:0] st_data = '0;
   logic st_full, m_valid, m_last, frame_done, overflow;
   logic [7:0] m_data;
   logic [18:0] pix_count;
   typedef struct {
      logic [7:0] d;
      int idx;
   } exp_t;
   exp_t sb[$];
   int widx = 0;
   int n_vec = 0;
   int n_err = 0;
   bit ovf_m = 1'b0;
   bit fd_m = 1'b0;
   pixel_out_reader #(.DATA_W(8), .DEPTH(DEPTH), .FRAME_PIXELS(FP), .CNT_W(19)) dut (
      .clk(clk),
      .rst(rst_n),
      .st_en(st_en),
      .st_data(st_data),
      .st_full(st_full),
      .m_valid(m_valid),
      .m_data(m_data),
      .m_last(m_last),
      .m_ready(m_ready),
      .frame_done(frame_done),
      .pix_count(pix_count),
      .overflow(overflow)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      st_en = 1'b0;
      m_ready = 1'b0;
      #1;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_st_full", st_full, 0);
      chk("rst_pix_count", pix_count, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_overflow", overflow, 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      widx = 0;
      ovf_m = 1'b0;
      fd_m = 1'b0;
   endtask
   task automatic cyc(input bit en, input logic [7:0] d, input bit rdy);
      bit pop, push;
      int pc;
      st_en = en;
      st_data = d;
      m_ready = rdy;
      #1;
      pc = sb.size() != 0 ? sb[0].idx : widx;
      chk("m_valid", m_valid, sb.size() != 0);
      chk("st_full", st_full, sb.size() == DEPTH);
      chk("overflow", overflow, ovf_m);
      chk("frame_done", frame_done, fd_m);
      chk("pix_count", pix_count, pc);
      chk("m_last", m_last, sb.size() != 0 && pc == FP - 1);
      if (sb.size() != 0) chk("m_data", m_data, sb[0].d);
      pop = sb.size() != 0 && rdy;
      push = en && (sb.size() < DEPTH || pop);
      fd_m = pop && pc == FP - 1;
      if (en && !push) ovf_m = 1'b1;
      if (pop) void'(sb.pop_front());
      if (push) begin
         sb.push_back('{d, widx});
         widx = (widx + 1) % FP;
      end
      @(posedge clk);
      @(negedge clk);
   endtask
   initial begin
      @(negedge clk);
      do_reset();
      for (int i = 0; i < 3; i++) cyc(1, 8'h30 + 8'(i), 0);
      do_reset();
      cyc(1, 8'h55, 0);
      cyc(0, 0, 1);
      cyc(0, 0, 1);
      do_reset();
      for (int i = 0; i < 6; i++) cyc(1, 8'h10 + 8'(i), 1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1);
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1, 8'hA0 + 8'(i), 0);
      cyc(1, 8'hA4, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1);
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1, 8'hC0 + 8'(i), 0);
      cyc(1, 8'hB0, 1);
      cyc(0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1);
      do_reset();
      for (int i = 0; i < 12; i++) cyc(1, 8'(i), 1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1);
      do_reset();
      cyc(1, 8'h7E, 0);
      for (int i = 0; i < 5; i++) cyc(1, 8'h01 + 8'(i), 0);
      for (int i = 0; i < 6; i++) cyc(0, 0, 1);
      do_reset();
      for (int i = 0; i < 300; i++) cyc(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) != 0);
      for (int i = 0; i < 6; i++) cyc(0, 0, 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
